// File: rtl/adc_push_sequencer.sv
// Buffers raw 16-bit converter samples in a FIFO and pushes them to the correlator
// bank as one-cycle PushADC strobes, paced by a programmable gap and held off during bus writes.
module adc_push_sequencer #(
   parameter int          DEPTH = 16,
   parameter int          AW    = 4,
   parameter logic [31:0] BASE  = 32'hFE000200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] Wdata,
   input  logic        write,
   input  logic        read,
   output logic [31:0] Rdata,
   input  logic [15:0] SampleIn,
   input  logic        SampleValid,
   output logic        SampleReady,
   output logic [15:0] ADC,
   output logic        PushADC
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [15:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r;
   logic          enable_r, convert_r, overflow_r;
   logic [7:0]    gap_r, gapcnt_r;
   logic [31:0]   drop_cnt_r, push_cnt_r;

   logic ctrl_wr_s, flush_s, fifo_full_s, fifo_empty_s, push_in_s, drop_s, pop_s;
   logic [15:0] head_s;

   // Bus decode and FIFO handshake qualifiers; a write anywhere on the bus blocks the pop
   always_comb begin
      ctrl_wr_s    = write && (addr == BASE);
      flush_s      = ctrl_wr_s && Wdata[1];
      fifo_full_s  = (count_r == FULL_COUNT);
      fifo_empty_s = (count_r == {(AW+1){1'b0}});
      push_in_s    = SampleValid && !fifo_full_s && !flush_s;
      drop_s       = SampleValid && (fifo_full_s || flush_s);
      pop_s        = enable_r && !fifo_empty_s && (gapcnt_r == 8'd0) && !write && !flush_s;
      head_s       = mem_r[rd_ptr_r];
   end

   assign SampleReady = !fifo_full_s;

   // Sample storage; contents are only meaningful under count, so no reset is needed
   always_ff @(posedge clk) begin
      if (push_in_s) begin
         mem_r[wr_ptr_r] <= SampleIn;
      end
   end

   // FIFO pointers and fill count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_in_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({push_in_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Output stage, pacing counter and push counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ADC        <= 16'h0000;
         PushADC    <= 1'b0;
         gapcnt_r   <= 8'd0;
         push_cnt_r <= 32'd0;
      end else begin
         PushADC <= pop_s;
         if (pop_s) begin
            ADC <= convert_r ? {~head_s[15], head_s[14:0]} : head_s;
         end
         if (flush_s)                 gapcnt_r <= 8'd0;
         else if (pop_s)              gapcnt_r <= gap_r;
         else if (gapcnt_r != 8'd0)   gapcnt_r <= gapcnt_r - 8'd1;
         // pops never coincide with bus writes, so load and increment cannot collide
         if (write && (addr == BASE + 32'h10)) push_cnt_r <= Wdata;
         else if (pop_s)                       push_cnt_r <= push_cnt_r + 32'd1;
      end
   end

   // Control registers, drop counter and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_r   <= 1'b0;
         convert_r  <= 1'b0;
         gap_r      <= 8'd0;
         drop_cnt_r <= 32'd0;
         overflow_r <= 1'b0;
      end else begin
         if (ctrl_wr_s) begin
            enable_r  <= Wdata[0];
            convert_r <= Wdata[2];
         end
         if (write && (addr == BASE + 32'h4)) gap_r <= Wdata[7:0];
         // a drop landing on the clearing write is still counted
         if (write && (addr == BASE + 32'hC)) begin
            drop_cnt_r <= drop_s ? 32'd1 : 32'd0;
            overflow_r <= drop_s;
         end else if (drop_s) begin
            if (drop_cnt_r != 32'hFFFFFFFF) drop_cnt_r <= drop_cnt_r + 32'd1;
            overflow_r <= 1'b1;
         end
      end
   end

   // Register read mux
   always_comb begin
      Rdata = 32'h0000_0000;
      if (!rst && read) begin
         case (addr)
            BASE:          Rdata = {29'd0, convert_r, 1'b0, enable_r};
            BASE + 32'h4:  Rdata = {24'd0, gap_r};
            BASE + 32'h8:  Rdata = {20'd0, overflow_r, fifo_full_s, fifo_empty_s, 9'(count_r)};
            BASE + 32'hC:  Rdata = drop_cnt_r;
            BASE + 32'h10: Rdata = push_cnt_r;
            default:       Rdata = 32'h0000_0000;
         endcase
      end else begin
         Rdata = 32'h0000_0000;
      end
   end

endmodule

// File: doc/adc_push_sequencer.md
Name: adc_push_sequencer

Overview:
- Upstream feeder for the correlator bank. Buffers raw 16-bit ADC samples from the converter interface in a FIFO.
- Presents each sample on ADC with a one-cycle PushADC strobe, paced by a programmable minimum gap.
- Holds pushes off during bus write cycles, so no sample arrives while a correlator ignores its DDS update.
- Controlled and monitored through the shared addr/Wdata/write/read register bus.

Parameters:
- DEPTH, 16, FIFO depth in samples (power of 2, 4..256).
- AW, 4, FIFO pointer width (log2 DEPTH).
- BASE, 32'hFE000200, register block base address.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  bus address.
- Wdata  in  32  bus write data.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- Rdata  out  32  bus read data (combinational).
- SampleIn  in  16  raw converter sample.
- SampleValid  in  1  SampleIn valid this cycle.
- SampleReady  out  1  FIFO not full (combinational from registered count).
- ADC  out  16  sample to correlators (registered).
- PushADC  out  1  one-cycle strobe, ADC valid (registered).

Behaviour:
- Registers (offset from BASE):
  - +0x0 Ctrl RW: bit0 enable; bit1 flush (self-clearing, reads 0); bit2 offset-binary convert.
  - +0x4 Gap RW [7:0]: minimum idle cycles between pushes.
  - +0x8 Status RO: [8:0] fill count; bit9 empty; bit10 full; bit11 overflow sticky.
  - +0xC DropCnt RO: any write clears it to 0 and clears overflow.
  - +0x10 PushCnt RW: write loads Wdata.
- Rdata = 0 when rst, !read, or unmatched addr. Writes to RO bits are ignored.
- Reset values: all registers, pointers, count and gap counter 0; ADC=0; PushADC=0. SampleReady=1 after reset.
- FIFO write: SampleValid && count!=DEPTH && !flush → write at the edge.
- Drop: SampleValid && (count==DEPTH || flush) → sample dropped, DropCnt+1 (saturates at 32'hFFFFFFFF), overflow set.
  - A pop in the same cycle does not rescue a sample arriving while full.
- Pop condition, evaluated each cycle: enable && count!=0 && gapcnt==0 && !write && !flush.
- On pop:
  - ADC <= head sample, or {~head[15],head[14:0]} when Ctrl[2]=1.
  - PushADC <= 1; PushCnt+1 (wraps); gapcnt <= Gap.
- Otherwise PushADC <= 0 and ADC holds its last value. gapcnt decrements toward 0 each cycle it is nonzero.
- Pacing: PushADC pulses are spaced at least Gap+1 cycles apart. Gap=0 allows back-to-back pushes.
- Latency: sample valid in cycle N into an empty FIFO, enabled, gapcnt 0 → PushADC high in cycle N+2.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Flush (write Ctrl with bit1=1):
  - Same edge: pointers, count and gapcnt <= 0; no pop that cycle.
  - Other Ctrl bits take Wdata.
  - Any PushADC already registered completes normally.
- Disable mid-stream: pushes stop at the next evaluation and the FIFO keeps filling. Re-enable resumes in order with no loss.
- Bus write to any address, in-range or not, blocks the pop in that cycle. The pop resumes the next cycle; gapcnt keeps counting.
- Reset mid-operation: all state clears immediately (asynchronous); PushADC drops without completing.

Test Plan:
- Reset, enable, Gap=0; drive 4 samples 0x0001..0x0004 back-to-back from cycle 10 → PushADC high cycles 12–15 with ADC 0x0001..0x0004; PushCnt=4.
- Gap=3, 3 queued samples → PushADC spaced exactly 4 cycles apart; Status count goes 3→0; empty=1 at end.
- Enable=0; drive 20 samples, DEPTH=16 → SampleReady falls after 16th; DropCnt=4; full=1; overflow=1. Write DropCnt → 0 and overflow cleared.
- Enabled, Gap=0, FIFO holding 5 samples; issue bus write to unrelated address for 2 cycles → no PushADC during those cycles; order preserved afterward; no sample lost.
- Ctrl[2]=1, input 0x8000 and 0x7FFF → ADC 0x0000 and 0xFFFF.
- Queue 6 samples, write flush while SampleValid=1 → count=0, DropCnt+1, no further PushADC. Assert rst mid-burst → PushADC=0, ADC=0 immediately; SampleReady=1.
